useq_ctrl: RTL and testbench



---
 rtl/useq_ctrl_if.sv | 26 ++
 rtl/useq_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_useq_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/useq_ctrl_if.sv
// useq_ctrl_if: sequencing bus between the control store / micro-PC counter
// and the microsequencer next-address controller.
interface useq_ctrl_if;
  logic [4:0] upc;
  logic [2:0] seq_op;
  logic [4:0] br_addr;
  logic [1:0] cond_sel;
  logic       cond_pol;
  logic [3:0] flags;
  logic       hold;
  logic       load_incr;
  logic [4:0] upc_next;
  logic       wait_busy;
  logic [3:0] depth;
  logic       stack_err;

  modport slave (
    input  upc, seq_op, br_addr, cond_sel, cond_pol, flags, hold,
    output load_incr, upc_next, wait_busy, depth, stack_err
  );

  modport master (
    output upc, seq_op, br_addr, cond_sel, cond_pol, flags, hold,
    input  load_incr, upc_next, wait_busy, depth, stack_err
  );
endinterface

// File: rtl/useq_ctrl.sv
// useq_ctrl: microsequencer next-address controller.
// Decodes the sequencing field of the current microinstruction into the
// micro-PC counter's load_incr/upc_next controls. Keeps a WAIT countdown
// FSM and, when built with `define USEQ_STACK_EN, a subroutine return stack
// with occupancy and a sticky overflow/underflow flag. Without the macro,
// CALL acts as JUMP, RET acts as CONT and no stack storage exists.
module useq_ctrl #(
  parameter int STACK_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  useq_ctrl_if.slave bus
);

  localparam logic [2:0] OP_CONT  = 3'd0;
  localparam logic [2:0] OP_JUMP  = 3'd1;
  localparam logic [2:0] OP_JCOND = 3'd2;
  localparam logic [2:0] OP_CALL  = 3'd3;
  localparam logic [2:0] OP_RET   = 3'd4;
  localparam logic [2:0] OP_WAIT  = 3'd5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

  // Reject unsupported stack sizes at elaboration time.
  if (STACK_DEPTH < 1 || STACK_DEPTH > 8) begin : g_depth_chk
    $error("useq_ctrl: STACK_DEPTH must be within 1..8");
  end

  state_t     state_r;
  state_t     state_nxt_s;
  logic [4:0] cnt_r;
  logic [4:0] cnt_nxt_s;
  logic [4:0] upc_inc_s;
  logic       cond_s;
  logic       load_incr_s;
  logic [4:0] upc_next_s;
  logic       ret_ok_s;
  logic [4:0] ret_addr_s;

  assign upc_inc_s = bus.upc + 5'd1;
  assign cond_s    = bus.flags[bus.cond_sel] ^ bus.cond_pol;

  // WAIT FSM state register; async reset drops any countdown in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 5'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // WAIT FSM next state; hold freezes the countdown in place.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    if (bus.hold) begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.seq_op == OP_WAIT && bus.br_addr != 5'd0) begin
            state_nxt_s = ST_COUNT;
            cnt_nxt_s   = bus.br_addr - 5'd1;
          end else begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = cnt_r;
          end
        end
        ST_COUNT: begin
          if (cnt_r != 5'd0) begin
            state_nxt_s = ST_COUNT;
            cnt_nxt_s   = cnt_r - 5'd1;
          end else begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = cnt_r;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 5'd0;
        end
      endcase
    end
  end

  // Next-address decode; a held micro-PC is expressed as a reload of upc.
  always_comb begin
    load_incr_s = 1'b0;
    upc_next_s  = upc_inc_s;
    if (bus.hold) begin
      load_incr_s = 1'b1;
      upc_next_s  = bus.upc;
    end else if (state_r == ST_COUNT) begin
      // The control store keeps presenting the WAIT word, so seq_op is ignored.
      if (cnt_r != 5'd0) begin
        load_incr_s = 1'b1;
        upc_next_s  = bus.upc;
      end else begin
        load_incr_s = 1'b0;
        upc_next_s  = upc_inc_s;
      end
    end else begin
      case (bus.seq_op)
        OP_CONT: begin
          load_incr_s = 1'b0;
          upc_next_s  = upc_inc_s;
        end
        OP_JUMP: begin
          load_incr_s = 1'b1;
          upc_next_s  = bus.br_addr;
        end
        OP_JCOND: begin
          if (cond_s) begin
            load_incr_s = 1'b1;
            upc_next_s  = bus.br_addr;
          end else begin
            load_incr_s = 1'b0;
            upc_next_s  = upc_inc_s;
          end
        end
        OP_CALL: begin
          // The target is taken even when a full stack refuses the push.
          load_incr_s = 1'b1;
          upc_next_s  = bus.br_addr;
        end
        OP_RET: begin
          if (ret_ok_s) begin
            load_incr_s = 1'b1;
            upc_next_s  = ret_addr_s;
          end else begin
            load_incr_s = 1'b0;
            upc_next_s  = upc_inc_s;
          end
        end
        OP_WAIT: begin
          if (bus.br_addr != 5'd0) begin
            load_incr_s = 1'b1;
            upc_next_s  = bus.upc;
          end else begin
            load_incr_s = 1'b0;
            upc_next_s  = upc_inc_s;
          end
        end
        default: begin
          load_incr_s = 1'b0;
          upc_next_s  = upc_inc_s;
        end
      endcase
    end
  end

`ifdef USEQ_STACK_EN
  localparam int         IDX_W     = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int         SLOTS     = 1 << IDX_W;
  localparam logic [3:0] DEPTH_MAX = 4'(STACK_DEPTH);

  logic [4:0]       stack_r [SLOTS];
  logic [3:0]       depth_r;
  logic             stack_err_r;
  logic [IDX_W-1:0] push_idx_s;
  logic [IDX_W-1:0] top_idx_s;
  logic             do_call_s;
  logic             do_ret_s;

  // Stack ops only happen when the sequencer is actually decoding seq_op.
  assign do_call_s  = !bus.hold && (state_r == ST_IDLE) && (bus.seq_op == OP_CALL);
  assign do_ret_s   = !bus.hold && (state_r == ST_IDLE) && (bus.seq_op == OP_RET);
  assign push_idx_s = depth_r[IDX_W-1:0];
  assign top_idx_s  = IDX_W'(depth_r - 4'd1);
  assign ret_ok_s   = (depth_r != 4'd0);
  assign ret_addr_s = stack_r[top_idx_s];

  // Return stack push/pop and sticky overflow/underflow flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SLOTS; i++) begin
        stack_r[i] <= 5'd0;
      end
      depth_r     <= 4'd0;
      stack_err_r <= 1'b0;
    end else if (do_call_s) begin
      if (depth_r == DEPTH_MAX) begin
        stack_err_r <= 1'b1;
      end else begin
        stack_r[push_idx_s] <= upc_inc_s;
        depth_r             <= depth_r + 4'd1;
      end
    end else if (do_ret_s) begin
      if (depth_r == 4'd0) begin
        stack_err_r <= 1'b1;
      end else begin
        depth_r <= depth_r - 4'd1;
      end
    end else begin
      depth_r <= depth_r;
    end
  end

  assign bus.depth     = depth_r;
  assign bus.stack_err = stack_err_r;
`else
  assign ret_ok_s      = 1'b0;
  assign ret_addr_s    = 5'd0;
  assign bus.depth     = 4'd0;
  assign bus.stack_err = 1'b0;
`endif

  assign bus.load_incr = load_incr_s;
  assign bus.upc_next  = upc_next_s;
  assign bus.wait_busy = (state_r == ST_COUNT);

endmodule

// File: tb/tb_useq_ctrl.sv
// tb_useq_ctrl: self-checking bench for useq_ctrl. The bench plays the
// micro-PC counter and keeps a behavioural model (queue stack, WAIT as
// elapsed-vs-N cycle count) that predicts every output.
module tb_useq_ctrl;

  localparam int SD = 4;
`ifdef USEQ_STACK_EN
  localparam bit STACK_EN = 1'b1;
`else
  localparam bit STACK_EN = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] op;
    logic [4:0] br;
    logic [1:0] sel;
    logic       pol;
    logic [3:0] fl;
    logic       hd;
  } stim_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;

  useq_ctrl_if bif ();

  useq_ctrl #(.STACK_DEPTH(SD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif)
  );

  always #5 clk = ~clk;

  // Model state
  logic [4:0] m_upc;
  logic [4:0] m_stk[$];
  logic       m_err;
  logic       m_in_wait;
  int         m_wait_n;
  int         m_elapsed;
  logic       exp_li;
  logic [4:0] exp_nx;

  function automatic stim_t mk(input logic [2:0] op, input logic [4:0] br,
                               input logic [1:0] sel, input logic pol,
                               input logic [3:0] fl, input logic hd);
    stim_t s;
    s.op = op; s.br = br; s.sel = sel; s.pol = pol; s.fl = fl; s.hd = hd;
    return s;
  endfunction

  task automatic model_reset();
    m_stk.delete();
    m_err = 1'b0;
    m_in_wait = 1'b0;
    m_wait_n = 0;
    m_elapsed = 0;
    m_upc = 5'd0;
  endtask

  // Predict this cycle's outputs and advance the model past the next edge.
  task automatic model_step(input stim_t s);
    logic c;
    exp_li = 1'b0;
    exp_nx = m_upc + 5'd1;
    if (s.hd) begin
      exp_li = 1'b1;
      exp_nx = m_upc;
    end else if (m_in_wait) begin
      if (m_elapsed < m_wait_n) begin
        exp_li = 1'b1;
        exp_nx = m_upc;
        m_elapsed++;
      end else begin
        m_in_wait = 1'b0;
      end
    end else begin
      case (s.op)
        3'd1: begin exp_li = 1'b1; exp_nx = s.br; end
        3'd2: begin
          c = s.fl[s.sel] ^ s.pol;
          if (c) begin exp_li = 1'b1; exp_nx = s.br; end
        end
        3'd3: begin
          exp_li = 1'b1;
          exp_nx = s.br;
          if (STACK_EN) begin
            if (m_stk.size() == SD) m_err = 1'b1;
            else m_stk.push_back(m_upc + 5'd1);
          end
        end
        3'd4: begin
          if (STACK_EN && m_stk.size() > 0) begin
            exp_li = 1'b1;
            exp_nx = m_stk.pop_back();
          end else if (STACK_EN) begin
            m_err = 1'b1;
          end
        end
        3'd5: begin
          if (s.br != 5'd0) begin
            exp_li = 1'b1;
            exp_nx = m_upc;
            m_in_wait = 1'b1;
            m_wait_n = int'(s.br);
            m_elapsed = 1;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic drive(input stim_t s);
    bif.upc      = m_upc;
    bif.seq_op   = s.op;
    bif.br_addr  = s.br;
    bif.cond_sel = s.sel;
    bif.cond_pol = s.pol;
    bif.flags    = s.fl;
    bif.hold     = s.hd;
    model_step(s);
  endtask

  // Clock edge; the bench acts as the micro-PC counter.
  task automatic tick();
    @(posedge clk);
    #1;
    m_upc = exp_li ? exp_nx : m_upc + 5'd1;
  endtask

  task automatic test_reset();
    model_reset();
    reset_n = 1'b0;
    drive(mk(3'd0, 5'd0, 2'd0, 1'b0, 4'd0, 1'b0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_run++;
    if (bif.wait_busy !== 1'b0 || bif.depth !== 4'd0 || bif.stack_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_regs: busy=%b depth=%0d err=%b, required 0/0/0",
               bif.wait_busy, bif.depth, bif.stack_err);
    end
    n_run++;
    if (bif.load_incr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cont: load_incr=%b, required 0", bif.load_incr);
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    m_upc = 5'd0;
  endtask

  task automatic test_decode();
    stim_t q[$];
    m_upc = 5'd5;
    q.push_back(mk(3'd0, 5'd9,  2'd0, 1'b0, 4'b0000, 1'b0));
    q.push_back(mk(3'd1, 5'd17, 2'd0, 1'b0, 4'b0000, 1'b0));
    q.push_back(mk(3'd2, 5'd20, 2'd2, 1'b0, 4'b0100, 1'b0));
    q.push_back(mk(3'd2, 5'd3,  2'd2, 1'b1, 4'b0100, 1'b0));
    q.push_back(mk(3'd2, 5'd11, 2'd1, 1'b1, 4'b0100, 1'b0));
    q.push_back(mk(3'd1, 5'd25, 2'd0, 1'b0, 4'b0000, 1'b1));
    q.push_back(mk(3'd6, 5'd30, 2'd0, 1'b0, 4'b0000, 1'b0));
    q.push_back(mk(3'd7, 5'd30, 2'd0, 1'b0, 4'b0000, 1'b0));
    foreach (q[i]) begin
      drive(q[i]);
      @(negedge clk);
      n_run++;
      if (bif.load_incr !== exp_li || (exp_li && bif.upc_next !== exp_nx)) begin
        n_fail++;
        $display("FAIL decode[%0d]: load_incr=%b upc_next=%0d, required %b/%0d",
                 i, bif.load_incr, bif.upc_next, exp_li, exp_nx);
      end
      tick();
    end
  endtask

  task automatic test_stack();
    stim_t q[$];
    m_upc = 5'd31;
    q.push_back(mk(3'd3, 5'd8, 2'd0, 1'b0, 4'd0, 1'b0));
    q.push_back(mk(3'd4, 5'd0, 2'd0, 1'b0, 4'd0, 1'b0));
    for (int k = 0; k < 5; k++) q.push_back(mk(3'd3, 5'(4 * k + 2), 2'd0, 1'b0, 4'd0, 1'b0));
    for (int k = 0; k < 5; k++) q.push_back(mk(3'd4, 5'd0, 2'd0, 1'b0, 4'd0, 1'b0));
    foreach (q[i]) begin
      drive(q[i]);
      @(negedge clk);
      n_run++;
      if (bif.load_incr !== exp_li || (exp_li && bif.upc_next !== exp_nx)) begin
        n_fail++;
        $display("FAIL stack[%0d]: load_incr=%b upc_next=%0d, required %b/%0d",
                 i, bif.load_incr, bif.upc_next, exp_li, exp_nx);
      end
      tick();
      n_run++;
      if (bif.depth !== 4'(m_stk.size()) || bif.stack_err !== m_err) begin
        n_fail++;
        $display("FAIL stack_state[%0d]: depth=%0d err=%b, required %0d/%b",
                 i, bif.depth, bif.stack_err, m_stk.size(), m_err);
      end
    end
  endtask

  task automatic test_wait();
    stim_t q[$];
    int held;
    held = 0;
    for (int k = 0; k < 4; k++) q.push_back(mk(3'd5, 5'd3, 2'd0, 1'b0, 4'd0, 1'b0));
    q.push_back(mk(3'd0, 5'd0, 2'd0, 1'b0, 4'd0, 1'b0));
    q.push_back(mk(3'd5, 5'd3, 2'd0, 1'b0, 4'd0, 1'b0));
    q.push_back(mk(3'd5, 5'd3, 2'd0, 1'b0, 4'd0, 1'b1));
    q.push_back(mk(3'd5, 5'd3, 2'd0, 1'b0, 4'd0, 1'b1));
    for (int k = 0; k < 3; k++) q.push_back(mk(3'd5, 5'd3, 2'd0, 1'b0, 4'd0, 1'b0));
    q.push_back(mk(3'd0, 5'd0, 2'd0, 1'b0, 4'd0, 1'b0));
    q.push_back(mk(3'd5, 5'd0, 2'd0, 1'b0, 4'd0, 1'b0));
    foreach (q[i]) begin
      drive(q[i]);
      @(negedge clk);
      if (i < 4 && bif.load_incr === 1'b1) held++;
      n_run++;
      if (bif.load_incr !== exp_li || (exp_li && bif.upc_next !== exp_nx)) begin
        n_fail++;
        $display("FAIL wait[%0d]: load_incr=%b upc_next=%0d, required %b/%0d",
                 i, bif.load_incr, bif.upc_next, exp_li, exp_nx);
      end
      tick();
      n_run++;
      if (bif.wait_busy !== m_in_wait) begin
        n_fail++;
        $display("FAIL wait_busy[%0d]: wait_busy=%b, required %b", i, bif.wait_busy, m_in_wait);
      end
    end
    n_run++;
    if (held != 3) begin
      n_fail++;
      $display("FAIL wait_n3_held: held cycles=%0d, required 3", held);
    end
  endtask

  task automatic test_random();
    stim_t s;
    for (int i = 0; i < 400; i++) begin
      s.op  = 3'($urandom_range(0, 7));
      s.br  = (s.op == 3'd5) ? 5'($urandom_range(0, 5)) : 5'($urandom_range(0, 31));
      s.sel = 2'($urandom_range(0, 3));
      s.pol = 1'($urandom_range(0, 1));
      s.fl  = 4'($urandom_range(0, 15));
      s.hd  = ($urandom_range(0, 7) == 0);
      drive(s);
      @(negedge clk);
      n_run++;
      if (bif.load_incr !== exp_li || (exp_li && bif.upc_next !== exp_nx)) begin
        n_fail++;
        $display("FAIL random[%0d]: op=%0d load_incr=%b upc_next=%0d, required %b/%0d",
                 i, s.op, bif.load_incr, bif.upc_next, exp_li, exp_nx);
      end
      tick();
      n_run++;
      if (bif.wait_busy !== m_in_wait || bif.depth !== 4'(m_stk.size()) || bif.stack_err !== m_err) begin
        n_fail++;
        $display("FAIL random_state[%0d]: busy=%b depth=%0d err=%b, required %b/%0d/%b",
                 i, bif.wait_busy, bif.depth, bif.stack_err, m_in_wait, m_stk.size(), m_err);
      end
    end
  endtask

  task automatic test_reset_midwait();
    stim_t q[$];
    model_reset();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    q.push_back(mk(3'd3, 5'd12, 2'd0, 1'b0, 4'd0, 1'b0));
    q.push_back(mk(3'd3, 5'd20, 2'd0, 1'b0, 4'd0, 1'b0));
    q.push_back(mk(3'd5, 5'd5,  2'd0, 1'b0, 4'd0, 1'b0));
    q.push_back(mk(3'd5, 5'd5,  2'd0, 1'b0, 4'd0, 1'b0));
    foreach (q[i]) begin
      drive(q[i]);
      tick();
    end
    n_run++;
    if (bif.wait_busy !== 1'b1 || bif.depth !== 4'(m_stk.size())) begin
      n_fail++;
      $display("FAIL pre_reset: busy=%b depth=%0d, required 1/%0d",
               bif.wait_busy, bif.depth, m_stk.size());
    end
    reset_n = 1'b0;
    #2;
    n_run++;
    if (bif.wait_busy !== 1'b0 || bif.depth !== 4'd0 || bif.stack_err !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: busy=%b depth=%0d err=%b, required 0/0/0",
               bif.wait_busy, bif.depth, bif.stack_err);
    end
    model_reset();
    drive(mk(3'd5, 5'd5, 2'd0, 1'b0, 4'd0, 1'b0));
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_run++;
    if (bif.load_incr !== exp_li || (exp_li && bif.upc_next !== exp_nx)) begin
      n_fail++;
      $display("FAIL post_reset: load_incr=%b upc_next=%0d, required %b/%0d",
               bif.load_incr, bif.upc_next, exp_li, exp_nx);
    end
    tick();
    n_run++;
    if (bif.wait_busy !== m_in_wait || bif.depth !== 4'(m_stk.size())) begin
      n_fail++;
      $display("FAIL post_reset_state: busy=%b depth=%0d, required %b/%0d",
               bif.wait_busy, bif.depth, m_in_wait, m_stk.size());
    end
  endtask

  initial begin
    bif.upc = 5'd0; bif.seq_op = 3'd0; bif.br_addr = 5'd0; bif.cond_sel = 2'd0;
    bif.cond_pol = 1'b0; bif.flags = 4'd0; bif.hold = 1'b0;
    test_reset();
    test_decode();
    test_stack();
    test_wait();
    test_random();
    test_reset_midwait();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
